uart_csr_fifo: RTL and testbench

Second-generation UART control/status register block. It keeps the same flat CSR read/write port as the current CSR block and adds parametrised TX and RX data FIFOs. It also adds a sticky interrupt status register (write-1-to-clear), an interrupt enable register with a single `irq` output, and FIFO level reporting. It sits between the CPU memory-mapped bus and the UART TX/RX engines, which use valid/ready handshakes.

---
 rtl/uart_csr_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_csr_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_fifo.sv
// UART control/status block: flat CSR read/write port, TX/RX data FIFOs,
// sticky write-1-to-clear interrupt status and a single registered irq.

module uart_csr_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A same-cycle pop frees a slot even when full; a flush swallows the push silently.
  assign push_ok    = push_i && !flush_i && (!full_o || pop_ok);
  assign overflow_o = push_i && !flush_i && full_o && !pop_ok;
  assign head_o     = mem_q[rptr_q];
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (flush_i)
      count_d = '0;
    else if (push_ok && !pop_ok)
      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + PW'(1);
        if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end
endmodule

module uart_csr_fifo #(
  parameter int CSR_DATA_W  = 32,
  parameter int CSR_ADDR_W  = 4,
  parameter int UART_DATA_W = 8,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int BAUD_RST    = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CSR_ADDR_W-1:0]  wr_addr,
  input  logic [CSR_DATA_W-1:0]  wr_data,
  input  logic                   wen,
  input  logic [CSR_ADDR_W-1:0]  rd_addr,
  output logic [CSR_DATA_W-1:0]  rd_data,
  input  logic                   ren,
  output logic [CSR_DATA_W-1:0]  baud_div,
  output logic [3:0]             data_bits,
  output logic                   parity_en,
  output logic                   parity_odd,
  output logic                   stop2,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   parity_error,
  input  logic                   busy,
  output logic                   irq
);
  localparam logic [CSR_ADDR_W-1:0] A_BAUD   = CSR_ADDR_W'(0);
  localparam logic [CSR_ADDR_W-1:0] A_CTRL   = CSR_ADDR_W'(1);
  localparam logic [CSR_ADDR_W-1:0] A_STATUS = CSR_ADDR_W'(2);
  localparam logic [CSR_ADDR_W-1:0] A_TXDATA = CSR_ADDR_W'(3);
  localparam logic [CSR_ADDR_W-1:0] A_RXDATA = CSR_ADDR_W'(4);
  localparam logic [CSR_ADDR_W-1:0] A_INTEN  = CSR_ADDR_W'(5);
  localparam logic [CSR_ADDR_W-1:0] A_INTST  = CSR_ADDR_W'(6);
  localparam logic [CSR_ADDR_W-1:0] A_LEVEL  = CSR_ADDR_W'(7);

  logic [CSR_DATA_W-1:0]      baud_q, rd_data_q, rd_data_d;
  logic [8:0]                 ctrl_q;
  logic [4:0]                 int_en_q, int_status_q, int_set, int_clr;
  logic                       irq_q;
  logic                       wr_ctrl, wr_tx, tx_flush, rx_flush, rx_pop_req;
  logic                       tx_pop, rx_push, data_bits_err, tx_drained;
  logic [UART_DATA_W-1:0]     tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0]  tx_count;
  logic [$clog2(RX_DEPTH):0]  rx_count;
  logic                       tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf;

  assign wr_ctrl    = wen && (wr_addr == A_CTRL);
  assign wr_tx      = wen && (wr_addr == A_TXDATA);
  assign tx_flush   = wr_ctrl && wr_data[9];
  assign rx_flush   = wr_ctrl && wr_data[10];
  assign rx_pop_req = ren && (rd_addr == A_RXDATA);
  assign tx_valid   = ctrl_q[7] && !tx_empty;
  assign tx_pop     = tx_valid && tx_ready;
  assign rx_push    = rx_valid && ctrl_q[8];
  assign tx_data    = tx_head;

  uart_csr_fifo_buf #(.W(UART_DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush_i(tx_flush), .push_i(wr_tx),
    .data_i(wr_data[UART_DATA_W-1:0]), .pop_i(tx_pop), .head_o(tx_head),
    .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty), .overflow_o(tx_ovf)
  );

  uart_csr_fifo_buf #(.W(UART_DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush_i(rx_flush), .push_i(rx_push),
    .data_i(rx_data), .pop_i(rx_pop_req), .head_o(rx_head),
    .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty), .overflow_o(rx_ovf)
  );

  // With DEPTH >= 2 a push at count 1 always lands, so only a flush or a lone pop empties it.
  assign tx_drained    = (tx_count == 1) && (tx_flush || (tx_pop && !wr_tx));
  assign data_bits_err = (ctrl_q[3:0] < 4'd5) || (ctrl_q[3:0] > 4'd8);
  assign int_set       = {tx_ovf, parity_error, rx_ovf, tx_drained, rx_push};
  assign int_clr       = (wen && (wr_addr == A_INTST)) ? wr_data[4:0] : 5'd0;

  always_comb begin
    rd_data_d = rd_data_q;
    if (ren) begin
      rd_data_d = '0;
      case (rd_addr)
        A_BAUD:   rd_data_d = baud_q;
        A_CTRL:   rd_data_d = CSR_DATA_W'(ctrl_q);
        A_STATUS: rd_data_d = CSR_DATA_W'({data_bits_err, busy, rx_empty, rx_full,
                                           tx_empty, tx_full});
        A_RXDATA: if (!rx_empty) rd_data_d = CSR_DATA_W'(rx_head);
        A_INTEN:  rd_data_d = CSR_DATA_W'(int_en_q);
        A_INTST:  rd_data_d = CSR_DATA_W'(int_status_q);
        A_LEVEL:  rd_data_d = CSR_DATA_W'({16'(rx_count), 16'(tx_count)});
        default:  rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_q       <= CSR_DATA_W'(BAUD_RST);
      ctrl_q       <= 9'h008;
      int_en_q     <= '0;
      int_status_q <= '0;
      rd_data_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      irq_q        <= |(int_status_q & int_en_q);
      int_status_q <= (int_status_q & ~int_clr) | int_set;
      if (wen) begin
        case (wr_addr)
          A_BAUD:  baud_q   <= wr_data;
          A_CTRL:  ctrl_q   <= wr_data[8:0];
          A_INTEN: int_en_q <= wr_data[4:0];
          default: ;
        endcase
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign irq        = irq_q;
  assign baud_div   = baud_q;
  assign data_bits  = ctrl_q[3:0];
  assign parity_en  = ctrl_q[4];
  assign parity_odd = ctrl_q[5];
  assign stop2      = ctrl_q[6];
endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed + randomized bench for uart_csr_fifo against a queue-based CSR model.
module tb_uart_csr_fifo;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] rd_data, baud_div;
  logic [3:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic [7:0]  tx_data;
  logic        tx_valid, irq;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, parity_error = 1'b0, busy = 1'b0;

  uart_csr_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
    .rd_addr(rd_addr), .rd_data(rd_data), .ren(ren), .baud_div(baud_div),
    .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  // Reference model state
  logic [31:0] m_baud, m_rd;
  logic [8:0]  m_ctrl;
  logic [4:0]  m_inten, m_ist;
  logic        m_irq;
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      4'd0: v = m_baud;
      4'd1: v = {23'd0, m_ctrl};
      4'd2: v = {26'd0, (m_ctrl[3:0] < 5 || m_ctrl[3:0] > 8), busy,
                 rxq.size() == 0, rxq.size() == RXD, txq.size() == 0, txq.size() == TXD};
      4'd4: if (rxq.size() > 0) v = {24'd0, rxq[0]};
      4'd5: v = {27'd0, m_inten};
      4'd6: v = {27'd0, m_ist};
      4'd7: v = {16'(rxq.size()), 16'(txq.size())};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [4:0] set_v, clr_v;
    logic       irq_n, tx_pop, rx_pop, fl_tx, fl_rx, tx_push, rx_push;
    int         old_tx;
    if (!rst_n) begin
      m_baud = 32'd434; m_ctrl = 9'h008; m_inten = '0; m_ist = '0;
      m_irq = 1'b0; m_rd = '0;
      txq.delete(); rxq.delete();
      return;
    end
    if (ren) m_rd = model_read(rd_addr);
    irq_n   = |(m_ist & m_inten);
    tx_pop  = m_ctrl[7] && txq.size() > 0 && tx_ready;
    rx_pop  = ren && rd_addr == 4'd4 && rxq.size() > 0;
    fl_tx   = wen && wr_addr == 4'd1 && wr_data[9];
    fl_rx   = wen && wr_addr == 4'd1 && wr_data[10];
    tx_push = wen && wr_addr == 4'd3;
    rx_push = rx_valid && m_ctrl[8];
    set_v   = {1'b0, parity_error, 2'b00, rx_push};
    old_tx  = txq.size();
    if (fl_tx) txq.delete();
    else begin
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) begin
        if (txq.size() < TXD) txq.push_back(wr_data[7:0]);
        else set_v[4] = 1'b1;
      end
    end
    set_v[1] = (old_tx == 1) && (txq.size() == 0);
    if (fl_rx) rxq.delete();
    else begin
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) begin
        if (rxq.size() < RXD) rxq.push_back(rx_data);
        else set_v[2] = 1'b1;
      end
    end
    clr_v = (wen && wr_addr == 4'd6) ? wr_data[4:0] : 5'd0;
    m_ist = (m_ist & ~clr_v) | set_v;
    m_irq = irq_n;
    if (wen) begin
      case (wr_addr)
        4'd0: m_baud = wr_data;
        4'd1: m_ctrl = wr_data[8:0];
        4'd5: m_inten = wr_data[4:0];
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic exp_txv;
    exp_txv = m_ctrl[7] && txq.size() > 0;
    check("rd_data", rd_data, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("tx_valid", {31'd0, tx_valid}, {31'd0, exp_txv});
    if (exp_txv) check("tx_data", {24'd0, tx_data}, {24'd0, txq[0]});
    check("baud_div", baud_div, m_baud);
    check("ctrl_out", {25'd0, stop2, parity_odd, parity_en, data_bits},
          {25'd0, m_ctrl[6:0]});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wen = 1'b1;
    cyc();
    wen = 1'b0;
    if (verbose) $display("[%0t] write addr=%0d data=0x%0h", $time, a, d);
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    rd_addr = a; ren = 1'b1;
    cyc();
    ren = 1'b0;
    d = rd_data;
    if (verbose) $display("[%0t] read  addr=%0d data=0x%0h", $time, a, d);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  saved[8];

    // 1. reset and read every address
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    csr_read(4'd0, r); check("rst_baud", r, 32'd434);
    csr_read(4'd1, r); check("rst_ctrl", r, 32'h008);
    csr_read(4'd2, r); check("rst_status", r, 32'h0A);
    csr_read(4'd3, r); check("rst_txdata", r, 32'd0);
    csr_read(4'd4, r); check("rst_rxdata", r, 32'd0);
    csr_read(4'd5, r); check("rst_inten", r, 32'd0);
    csr_read(4'd6, r); check("rst_intst", r, 32'd0);
    csr_read(4'd7, r); check("rst_level", r, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // 2. TX ordering and overflow
    csr_write(4'd1, 32'h008);
    for (int i = 0; i < 9; i++) csr_write(4'd3, 32'h41 + i);
    csr_read(4'd7, r); check("tx_level_full", {16'd0, r[15:0]}, 32'd8);
    csr_read(4'd6, r); check("tx_ovf_flag", {31'd0, r[4]}, 32'd1);
    tx_ready = 1'b1;
    csr_write(4'd1, 32'h088);
    for (int i = 0; i < 8; i++) begin
      check("tx_seq_valid", {31'd0, tx_valid}, 32'd1);
      check("tx_seq_data", {24'd0, tx_data}, 32'h41 + i);
      cyc();
    end
    check("tx_drained_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    csr_read(4'd6, r); check("tx_drained_flag", {31'd0, r[1]}, 32'd1);
    csr_write(4'd6, 32'h1F);
    csr_read(4'd6, r); check("w1c_all", r, 32'd0);

    // 3. RX overflow and irq
    csr_write(4'd1, 32'h108);
    for (int i = 0; i < 9; i++) rx_pulse(8'h10 + 8'(i));
    csr_read(4'd6, r); check("rx_intst", r, 32'h05);
    csr_write(4'd5, 32'h04);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    cyc();
    check("irq_after_en", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      csr_read(4'd4, r); check("rx_order", r, 32'h10 + i);
    end
    csr_read(4'd4, r); check("rx_empty_read", r, 32'd0);
    csr_read(4'd7, r); check("rx_level_zero", {16'd0, r[31:16]}, 32'd0);

    // 4. W1C versus same-cycle parity set
    csr_write(4'd6, 32'h1F);
    csr_write(4'd5, 32'h08);
    parity_error = 1'b1; cyc(); parity_error = 1'b0;
    parity_error = 1'b1;
    csr_write(4'd6, 32'h08);
    parity_error = 1'b0;
    csr_read(4'd6, r); check("w1c_race", {31'd0, r[3]}, 32'd1);
    check("irq_parity", {31'd0, irq}, 32'd1);
    csr_write(4'd6, 32'h08);
    check("irq_hold", {31'd0, irq}, 32'd1);
    cyc();
    check("irq_drop", {31'd0, irq}, 32'd0);
    csr_read(4'd6, r); check("parity_cleared", r, 32'd0);

    // 5. full RX with simultaneous pop and push
    for (int i = 0; i < 8; i++) begin
      saved[i] = 8'($urandom);
      rx_pulse(saved[i]);
    end
    rx_data = 8'h55; rx_valid = 1'b1;
    csr_read(4'd4, r);
    rx_valid = 1'b0;
    check("full_pop_head", r, {24'd0, saved[0]});
    csr_read(4'd7, r); check("full_level", {16'd0, r[31:16]}, 32'd8);
    csr_read(4'd6, r); check("full_no_ovf", {31'd0, r[2]}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      csr_read(4'd4, r); check("full_drain", r, {24'd0, saved[i]});
    end
    csr_read(4'd4, r); check("full_last_55", r, 32'h55);

    // 6. flush and data_bits check
    csr_write(4'd6, 32'h1F);
    for (int i = 0; i < 3; i++) rx_pulse(8'(8'hA0 + i));
    rx_data = 8'h77; rx_valid = 1'b1;
    csr_write(4'd1, 32'h508);
    rx_valid = 1'b0;
    csr_read(4'd7, r); check("flush_level", {16'd0, r[31:16]}, 32'd0);
    csr_read(4'd6, r); check("flush_no_ovf", {31'd0, r[2]}, 32'd0);
    csr_read(4'd1, r); check("flush_reads0", r, 32'h108);
    csr_write(4'd1, 32'h104);
    csr_read(4'd2, r); check("dbits_err_on", {31'd0, r[5]}, 32'd1);
    csr_write(4'd1, 32'h108);
    csr_read(4'd2, r); check("dbits_err_off", {31'd0, r[5]}, 32'd0);

    // randomized traffic against the model
    verbose = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      wen          = ($urandom_range(0, 2) == 0);
      wr_addr      = 4'($urandom_range(0, 15));
      wr_data      = $urandom;
      if (wr_addr == 4'd1) wr_data[10:9] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      ren          = $urandom_range(0, 1) == 1;
      rd_addr      = 4'($urandom_range(0, 9));
      rx_valid     = $urandom_range(0, 1) == 1;
      rx_data      = 8'($urandom);
      tx_ready     = $urandom_range(0, 2) == 0;
      parity_error = $urandom_range(0, 7) == 0;
      busy         = $urandom_range(0, 1) == 1;
      cyc();
    end
    wen = 1'b0; ren = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    parity_error = 1'b0; busy = 1'b0;
    verbose = 1'b1;

    // reset with FIFOs populated discards their contents
    csr_write(4'd1, 32'h108);
    for (int i = 0; i < 3; i++) csr_write(4'd3, 32'h60 + i);
    rx_pulse(8'h33);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    csr_read(4'd7, r); check("midrst_level", r, 32'd0);
    csr_read(4'd2, r); check("midrst_status", r, 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
